// File: rtl/emailbox_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : emailbox_arb_pkg
//  Description : Shared emesh packet geometry for the mailbox write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package emailbox_arb_pkg;

    localparam int EMESH_AW = 32;
    localparam int EMESH_PW = 2 * EMESH_AW + 40;

    // Burst counter width able to hold 0..quota inclusive.
    function automatic int quota_cnt_width(input int quota);
        return $clog2(quota + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/emailbox_arb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : oh_arbiter_rr
//  Description : Rotating-priority one-hot picker; search starts just past
//                the last owner and wraps modulo N, owner itself last.
//  Revision    : 1.0 - initial release
// ============================================================================
module oh_arbiter_rr #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_i,
    output logic [N-1:0] grant_o
);

    int   base_v;
    int   idx_v;
    logic found_v;

    always_comb begin
        grant_o = '0;
        found_v = 1'b0;
        base_v  = 0;
        idx_v   = 0;
        for (int j = 0; j < N; j++) begin
            if (last_i[j]) begin
                base_v = j;
            end
        end
        // Explicit modulo keeps non-power-of-two N from reaching invalid slots.
        for (int k = 1; k <= N; k++) begin
            idx_v = (base_v + k) % N;
            if (!found_v && req_i[idx_v]) begin
                grant_o[idx_v] = 1'b1;
                found_v        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/emailbox_arb.sv
`default_nettype none
// ============================================================================
//  Module      : emailbox_arb
//  Description : Round-robin arbiter with per-owner burst quota feeding the
//                mailbox emesh write port through a one-cycle register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module emailbox_arb
    import emailbox_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PW    = EMESH_PW,
    parameter int QUOTA = 4,
    parameter int NW    = $clog2(N),
    parameter int QW    = quota_cnt_width(QUOTA)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_access,
    input  logic [N*PW-1:0] req_packet,
    output logic [N-1:0]    req_wait,
    input  logic            mailbox_wait,
    output logic            emesh_access,
    output logic [PW-1:0]   emesh_packet,
    output logic [NW-1:0]   grant_id,
    output logic            busy
);

    logic [NW-1:0] owner_q;
    logic [NW-1:0] owner_d;
    logic [QW-1:0] cnt_q;
    logic [QW-1:0] cnt_d;
    logic          access_q;
    logic [PW-1:0] packet_q;
    logic [NW-1:0] grant_id_q;
    logic          busy_q;

    logic [N-1:0]  w_last_oh;
    logic [N-1:0]  w_rr_grant;
    logic [N-1:0]  w_grant;
    logic          w_cont;
    logic          w_any;
    logic [NW-1:0] w_win;
    logic [PW-1:0] w_pkt;
    logic [PW-1:0] w_pkts [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pkt_slice
        assign w_pkts[gi] = req_packet[gi*PW +: PW];
    end

    always_comb begin
        w_last_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_last_oh[i] = (owner_q == NW'(i));
        end
    end

    oh_arbiter_rr #(
        .N (N)
    ) u_rr (
        .req_i   (req_access),
        .last_i  (w_last_oh),
        .grant_o (w_rr_grant)
    );

    // Owner keeps the port while it still requests and has quota left.
    assign w_cont = (|(req_access & w_last_oh)) && (cnt_q != '0) && (cnt_q < QW'(QUOTA));

    always_comb begin
        if (mailbox_wait) begin
            w_grant = '0;
        end else if (w_cont) begin
            w_grant = w_last_oh;
        end else begin
            w_grant = w_rr_grant;
        end
    end

    assign w_any    = |w_grant;
    assign req_wait = req_access & ~w_grant;

    always_comb begin
        w_win = '0;
        w_pkt = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_win = NW'(i);
                w_pkt = w_pkts[i];
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!mailbox_wait) begin
            if (w_cont) begin
                cnt_d = cnt_q + QW'(1);
            end else if (w_any) begin
                owner_d = w_win;
                cnt_d   = QW'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= NW'(N - 1);
            cnt_q      <= '0;
            access_q   <= 1'b0;
            packet_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            busy_q   <= (cnt_d != '0);
            access_q <= w_any;
            if (w_any) begin
                packet_q   <= w_pkt;
                grant_id_q <= w_win;
            end
        end
    end

    assign emesh_access = access_q;
    assign emesh_packet = packet_q;
    assign grant_id     = grant_id_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_emailbox_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_emailbox_arb
//  Description : Self-checking bench for emailbox_arb (N=4/Q=4 and N=3/Q=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_emailbox_arb;

    localparam int PW = 104;

    typedef struct {
        logic [PW-1:0] pkt;
        int            id;
    } sb_item_t;

    logic            clk;
    logic            rst;
    logic            mbw;
    logic [3:0]      reqv;
    logic [PW-1:0]   pk [4];
    logic [4*PW-1:0] pkt_a;
    logic [3*PW-1:0] pkt_b;

    logic [3:0]    wait_a;
    logic          acc_a;
    logic [PW-1:0] pko_a;
    logic [1:0]    id_a;
    logic          busy_a;
    logic [2:0]    wait_b;
    logic          acc_b;
    logic [PW-1:0] pko_b;
    logic [1:0]    id_b;
    logic          busy_b;

    int            sel;
    logic [3:0]    obs_wait;
    logic          obs_acc;
    logic [PW-1:0] obs_pkt;
    logic [1:0]    obs_id;
    logic          obs_busy;

    int n_chk;
    int n_pass;
    int m_owner, m_cnt, mn, mq;
    int wl_cnt [4];
    sb_item_t sb [$];

    assign pkt_a = {pk[3], pk[2], pk[1], pk[0]};
    assign pkt_b = {pk[2], pk[1], pk[0]};

    emailbox_arb #(.N(4), .PW(PW), .QUOTA(4)) u_dut_a (
        .clk          (clk),
        .reset        (rst),
        .req_access   (reqv),
        .req_packet   (pkt_a),
        .req_wait     (wait_a),
        .mailbox_wait (mbw),
        .emesh_access (acc_a),
        .emesh_packet (pko_a),
        .grant_id     (id_a),
        .busy         (busy_a)
    );

    emailbox_arb #(.N(3), .PW(PW), .QUOTA(1)) u_dut_b (
        .clk          (clk),
        .reset        (rst),
        .req_access   (reqv[2:0]),
        .req_packet   (pkt_b),
        .req_wait     (wait_b),
        .mailbox_wait (mbw),
        .emesh_access (acc_b),
        .emesh_packet (pko_b),
        .grant_id     (id_b),
        .busy         (busy_b)
    );

    always_comb begin
        obs_wait = (sel != 0) ? {1'b0, wait_b} : wait_a;
        obs_acc  = (sel != 0) ? acc_b  : acc_a;
        obs_pkt  = (sel != 0) ? pko_b  : pko_a;
        obs_id   = (sel != 0) ? id_b   : id_a;
        obs_busy = (sel != 0) ? busy_b : busy_a;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v[PW-1:0];
    endfunction

    // Reference arbitration decision from the behavioural description.
    function automatic int model_pick(input logic [3:0] r, input logic m, output bit cont);
        cont = 1'b0;
        if (m) return -1;
        if (r[m_owner] && m_cnt > 0 && m_cnt < mq) begin
            cont = 1'b1;
            return m_owner;
        end
        for (int k = 1; k <= mn; k++) begin
            int i;
            i = (m_owner + k) % mn;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] r_in, input logic m, input logic rs);
        int         g;
        bit         cont;
        logic [3:0] r;
        logic [3:0] ew;
        sb_item_t   it;
        @(negedge clk);
        reqv = r_in;
        mbw  = m;
        rst  = rs;
        r    = r_in & ((4'b1 << mn) - 4'b1);
        g    = -1;
        #1;
        if (rs) begin
            m_owner = mn - 1;
            m_cnt   = 0;
            sb.delete();
        end else begin
            g  = model_pick(r, m, cont);
            ew = r;
            if (g >= 0) ew[g] = 1'b0;
            chk("req_wait", 128'(obs_wait), 128'(ew));
            for (int i = 0; i < 4; i++) begin
                if (r[i] && !obs_wait[i]) wl_cnt[i]++;
            end
            if (g >= 0) begin
                it.pkt = pk[g];
                it.id  = g;
                sb.push_back(it);
                if (cont) begin
                    m_cnt++;
                end else begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end else if (!m) begin
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rs) begin
            chk("rst_access", 128'(obs_acc), 128'(0));
            chk("rst_busy", 128'(obs_busy), 128'(0));
            chk("rst_grant_id", 128'(obs_id), 128'(0));
        end else begin
            chk("emesh_access", 128'(obs_acc), 128'(g >= 0));
            if (obs_acc) begin
                chk("sb_depth", 128'(sb.size()), 128'(1));
                if (sb.size() > 0) begin
                    it = sb.pop_front();
                    chk("emesh_packet", 128'(obs_pkt), 128'(it.pkt));
                    chk("grant_id", 128'(obs_id), 128'(it.id));
                end
            end
            chk("busy", 128'(obs_busy), 128'(m_cnt != 0));
            if (g >= 0) pk[g] = rnd_pkt();
        end
    endtask

    task automatic start(input int s);
        sel = s;
        mn  = (s != 0) ? 3 : 4;
        mq  = (s != 0) ? 1 : 4;
        for (int i = 0; i < 4; i++) wl_cnt[i] = 0;
        step(4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        int cnt2;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        mbw    = 1'b0;
        reqv   = 4'b0;
        for (int i = 0; i < 4; i++) pk[i] = rnd_pkt();

        // 1: all requesting, quota 4 rotation
        start(0);
        for (int k = 0; k < 18; k++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk("t1_seq", 128'(obs_id), 128'((k / 4) % 4));
        end

        // 2: lone requester 2
        start(0);
        cnt2 = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0100, 1'b0, 1'b0);
            if (obs_acc && obs_id == 2'd2) cnt2++;
            chk("t2_busy", 128'(obs_busy), 128'(1));
        end
        chk("t2_count", 128'(cnt2), 128'(10));

        // 3: mailbox_wait mid-burst of owner 1
        start(0);
        for (int k = 0; k < 6; k++) step(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("t3_blk_access", 128'(obs_acc), 128'(0));
        end
        step(4'b1111, 1'b0, 1'b0);
        chk("t3_resume_a", 128'(obs_id), 128'(1));
        step(4'b1111, 1'b0, 1'b0);
        chk("t3_resume_b", 128'(obs_id), 128'(1));
        step(4'b1111, 1'b0, 1'b0);
        chk("t3_rotate", 128'(obs_id), 128'(2));

        // 4: owner 0 drops after two grants
        start(0);
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        chk("t4_owner0", 128'(obs_id), 128'(0));
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, 1'b0, 1'b0);
            chk("t4_req1", 128'(obs_id), 128'(1));
        end
        step(4'b1010, 1'b0, 1'b0);
        chk("t4_req3", 128'(obs_id), 128'(3));

        // 5: reset mid-burst of owner 2
        start(0);
        for (int k = 0; k < 11; k++) step(4'b1111, 1'b0, 1'b0);
        chk("t5_pre_owner", 128'(obs_id), 128'(2));
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("t5_first", 128'(obs_id), 128'(0));

        // 6: N=3, QUOTA=1 strict rotation
        start(1);
        for (int k = 0; k < 6; k++) begin
            step(4'b0111, 1'b0, 1'b0);
            chk("t6_seq", 128'(obs_id), 128'(k % 3));
        end
        for (int i = 0; i < 3; i++) begin
            chk("t6_wait_low", 128'(wl_cnt[i]), 128'(2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
